// File: rtl/decode68k_ws_if.sv
// 68000 bus bundle between the main CPU core and the Alpha68k address decoder.
// nBERR is present only when DECODE68K_BERR_EN is defined.
interface decode68k_ws_if #(
    parameter int unsigned ADDR_W   = 22,
    parameter int unsigned SEL_BITS = 3
);
    localparam int unsigned NUM_REGIONS = 2 ** SEL_BITS;

    logic                   nAS;
    logic                   nUDS;
    logic                   nLDS;
    logic                   M68K_RW;
    logic [ADDR_W-1:0]      M68K_ADDR;
    logic [NUM_REGIONS-1:0] nREGION_SEL;
    logic                   nRD_U;
    logic                   nRD_L;
    logic                   nWR_U;
    logic                   nWR_L;
    logic                   nDTACK;
    logic                   nWD_RESET;
`ifdef DECODE68K_BERR_EN
    logic                   nBERR;

    modport master (
        output nAS, nUDS, nLDS, M68K_RW, M68K_ADDR,
        input  nREGION_SEL, nRD_U, nRD_L, nWR_U, nWR_L, nDTACK, nWD_RESET, nBERR
    );
    modport slave (
        input  nAS, nUDS, nLDS, M68K_RW, M68K_ADDR,
        output nREGION_SEL, nRD_U, nRD_L, nWR_U, nWR_L, nDTACK, nWD_RESET, nBERR
    );
`else
    modport master (
        output nAS, nUDS, nLDS, M68K_RW, M68K_ADDR,
        input  nREGION_SEL, nRD_U, nRD_L, nWR_U, nWR_L, nDTACK, nWD_RESET
    );
    modport slave (
        input  nAS, nUDS, nLDS, M68K_RW, M68K_ADDR,
        output nREGION_SEL, nRD_U, nRD_L, nWR_U, nWR_L, nDTACK, nWD_RESET
    );
`endif
endinterface

// File: rtl/decode68k_ws.sv
// Alpha68k main-CPU address decoder: region select, lane strobes, wait-state nDTACK and watchdog.
// Optional bus error on unmapped regions with DECODE68K_BERR_EN.
module decode68k_ws #(
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned SEL_BITS  = 3,
    parameter int unsigned WS_W      = 3,
    parameter logic [(2**SEL_BITS)*WS_W-1:0] WS_TABLE = '0,
    parameter int unsigned WD_REGION = 0,
    parameter int unsigned WD_SUB_LO = 15,
    parameter int unsigned WD_SUB_W  = 3,
    parameter int unsigned WD_SUB    = 5,
    parameter int unsigned WD_W      = 20,
    parameter logic [WD_W-1:0] WD_LIMIT = 20'hFFFFF,
    parameter int unsigned WD_PULSE  = 16,
    parameter logic [(2**SEL_BITS)-1:0] UNMAPPED = '0
) (
    input logic           CLK,
    input logic           nRESET,
    decode68k_ws_if.slave bus
);
    localparam int unsigned NUM_REGIONS = 2 ** SEL_BITS;
    localparam int unsigned PULSE_W     = (WD_PULSE < 1) ? 1 : $clog2(WD_PULSE + 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, BERR} state_t;

    state_t                 state, stateNext;
    logic [SEL_BITS-1:0]    region, regionNext, addrRegion;
    logic [WD_SUB_W-1:0]    sub, subNext;
    logic                   rw, rwNext;
    logic [WS_W-1:0]        waitCnt, waitNext, wsEntry;
    logic                   armed, armedNext;
    logic                   berrHit, laneOn, kick;
    logic [NUM_REGIONS-1:0] selQ, selNext;
    logic                   rdUQ, rdLQ, wrUQ, wrLQ, dtackQ;
    logic                   rdUNext, rdLNext, wrUNext, wrLNext, dtackNext;
    logic [WD_W-1:0]        wdCnt;
    logic [PULSE_W-1:0]     pulseCnt;
    logic                   nWdQ;
    logic                   unusedBits;

    assign addrRegion = bus.M68K_ADDR[ADDR_W-1 -: SEL_BITS];
    assign wsEntry    = WS_TABLE[32'(addrRegion)*WS_W +: WS_W];
    assign unusedBits = ^{bus.M68K_ADDR, UNMAPPED};

`ifdef DECODE68K_BERR_EN
    logic berrQ;
    assign berrHit   = UNMAPPED[addrRegion];
    assign bus.nBERR = berrQ;
`else
    assign berrHit   = 1'b0;
`endif

    // Next-state and next-output logic; armed records that nAS has been high since the last decode.
    always_comb begin
        stateNext  = state;
        regionNext = region;
        subNext    = sub;
        rwNext     = rw;
        waitNext   = waitCnt;
        armedNext  = armed | bus.nAS;
        case (state)
            IDLE: begin
                if (armed && !bus.nAS && (!bus.nUDS || !bus.nLDS)) begin
                    regionNext = addrRegion;
                    subNext    = bus.M68K_ADDR[WD_SUB_LO +: WD_SUB_W];
                    rwNext     = bus.M68K_RW;
                    waitNext   = wsEntry;
                    armedNext  = 1'b0;
                    if (berrHit)                    stateNext = BERR;
                    else if (wsEntry != WS_W'(0))   stateNext = WAIT;
                    else                            stateNext = ACK;
                end
            end
            WAIT: begin
                waitNext = waitCnt - WS_W'(1);
                if (bus.nAS)                        stateNext = IDLE;
                else if (waitCnt == WS_W'(1))       stateNext = ACK;
            end
            ACK:     if (bus.nAS) stateNext = IDLE;
            BERR:    if (bus.nAS) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        laneOn    = (stateNext == WAIT) || (stateNext == ACK);
        selNext   = (stateNext != IDLE) ? ~(NUM_REGIONS'(1) << regionNext) : '1;
        rdUNext   = ~(laneOn &  rwNext & ~bus.nUDS);
        rdLNext   = ~(laneOn &  rwNext & ~bus.nLDS);
        wrUNext   = ~(laneOn & ~rwNext & ~bus.nUDS);
        wrLNext   = ~(laneOn & ~rwNext & ~bus.nLDS);
        dtackNext = (stateNext != ACK);
        kick      = (stateNext == ACK) && (state != ACK) &&
                    (regionNext == SEL_BITS'(WD_REGION)) && (subNext == WD_SUB_W'(WD_SUB));
    end

    // FSM state, latched cycle attributes and registered bus outputs.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state   <= IDLE;
            region  <= '0;
            sub     <= '0;
            rw      <= 1'b1;
            waitCnt <= '0;
            armed   <= 1'b0;
            selQ    <= '1;
            rdUQ    <= 1'b1;
            rdLQ    <= 1'b1;
            wrUQ    <= 1'b1;
            wrLQ    <= 1'b1;
            dtackQ  <= 1'b1;
        end else begin
            state   <= stateNext;
            region  <= regionNext;
            sub     <= subNext;
            rw      <= rwNext;
            waitCnt <= waitNext;
            armed   <= armedNext;
            selQ    <= selNext;
            rdUQ    <= rdUNext;
            rdLQ    <= rdLNext;
            wrUQ    <= wrUNext;
            wrLQ    <= wrLNext;
            dtackQ  <= dtackNext;
        end
    end

`ifdef DECODE68K_BERR_EN
    always_ff @(posedge CLK) begin
        if (!nRESET) berrQ <= 1'b1;
        else         berrQ <= (stateNext != BERR);
    end
`endif

    // Watchdog: a kick beats the limit; counter is held at zero for the whole reset pulse.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            wdCnt    <= '0;
            pulseCnt <= '0;
            nWdQ     <= 1'b1;
        end else if (!nWdQ) begin
            wdCnt <= '0;
            if (pulseCnt <= PULSE_W'(1)) begin
                nWdQ     <= 1'b1;
                pulseCnt <= '0;
            end else begin
                pulseCnt <= pulseCnt - PULSE_W'(1);
            end
        end else if (kick) begin
            wdCnt <= '0;
        end else if (wdCnt == WD_LIMIT) begin
            wdCnt    <= '0;
            nWdQ     <= 1'b0;
            pulseCnt <= PULSE_W'(WD_PULSE);
        end else begin
            wdCnt <= wdCnt + WD_W'(1);
        end
    end

    assign bus.nREGION_SEL = selQ;
    assign bus.nRD_U       = rdUQ;
    assign bus.nRD_L       = rdLQ;
    assign bus.nWR_U       = wrUQ;
    assign bus.nWR_L       = wrLQ;
    assign bus.nDTACK      = dtackQ;
    assign bus.nWD_RESET   = nWdQ;
endmodule

// File: tb/tb_decode68k_ws.sv
// Directed bench for decode68k_ws: bus cycles checked through an expectation queue, plus watchdog timing.
module tb_decode68k_ws;
    typedef struct {
        logic [7:0] sel;
        logic [3:0] strb;
        int         lat;
    } exp_t;

    logic CLK;
    logic nRESET;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    decode68k_ws_if #(.ADDR_W(22), .SEL_BITS(3)) bus ();

    decode68k_ws #(
        .ADDR_W(22), .SEL_BITS(3), .WS_W(3),
        .WS_TABLE(24'h600050),
        .WD_REGION(0), .WD_SUB_LO(15), .WD_SUB_W(3), .WD_SUB(5),
        .WD_W(20), .WD_LIMIT(20'd100), .WD_PULSE(4),
        .UNMAPPED(8'h80)
    ) dut (
        .CLK(CLK),
        .nRESET(nRESET),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strb();
        return {bus.nRD_U, bus.nRD_L, bus.nWR_U, bus.nWR_L};
    endfunction

    task automatic chkIdle(input string tag);
        chk({tag, " sel"}, 32'(bus.nREGION_SEL), 32'hFF);
        chk({tag, " strobes"}, 32'(strb()), 32'hF);
        chk({tag, " dtack"}, 32'(bus.nDTACK), 32'd1);
`ifdef DECODE68K_BERR_EN
        chk({tag, " berr"}, 32'(bus.nBERR), 32'd1);
`endif
    endtask

    task automatic releaseBus();
        bus.nAS  = 1'b1;
        bus.nUDS = 1'b1;
        bus.nLDS = 1'b1;
    endtask

    task automatic doReset();
        releaseBus();
        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
    endtask

    // Push expectation, run one bus cycle, pop and compare when nDTACK arrives.
    task automatic busCycle(input logic [21:0] addr, input logic rw, input logic nu, input logic nl,
                            input logic [7:0] eSel, input logic [3:0] eStrb, input int eLat,
                            input string tag);
        exp_t e;
        int   n;
        bit   acked;
        e.sel = eSel; e.strb = eStrb; e.lat = eLat;
        sb.push_back(e);
        bus.M68K_ADDR = addr;
        bus.M68K_RW   = rw;
        bus.nUDS      = nu;
        bus.nLDS      = nl;
        bus.nAS       = 1'b0;
        n = 0;
        acked = 1'b0;
        while (!acked && n < 16) begin
            tick();
            n++;
            if (n == 1) chk({tag, " sel after decode"}, 32'(bus.nREGION_SEL), 32'(eSel));
            if (bus.nDTACK == 1'b0) acked = 1'b1;
        end
        e = sb.pop_front();
        if (!acked) begin
            chk({tag, " dtack timeout"}, 32'(bus.nDTACK), 32'd0);
        end else begin
            chk({tag, " latency"}, 32'(n), 32'(e.lat));
            chk({tag, " sel at ack"}, 32'(bus.nREGION_SEL), 32'(e.sel));
            chk({tag, " strobes at ack"}, 32'(strb()), 32'(e.strb));
        end
        releaseBus();
        tick();
        chkIdle({tag, " release"});
    endtask

    initial begin
        nRESET        = 1'b0;
        bus.M68K_ADDR = '0;
        bus.M68K_RW   = 1'b1;
        releaseBus();

        // Reset values, then region 1 read (2 wait states)
        doReset();
        chkIdle("reset");
        chk("reset wd", 32'(bus.nWD_RESET), 32'd1);
        tick();
        busCycle(22'h080000, 1'b1, 1'b0, 1'b0, 8'hFD, 4'b0011, 3, "rd r1");

        // Region 0 lower-lane write, zero wait states, back to back
        busCycle(22'h000100, 1'b0, 1'b1, 1'b0, 8'hFE, 4'b1110, 1, "wr r0");

        // Abort during WAIT, then an immediate normal cycle to region 2
        bus.M68K_ADDR = 22'h080000;
        bus.M68K_RW   = 1'b1;
        bus.nUDS      = 1'b0;
        bus.nLDS      = 1'b0;
        bus.nAS       = 1'b0;
        tick();
        chk("abort wait sel", 32'(bus.nREGION_SEL), 32'hFD);
        chk("abort wait dtack", 32'(bus.nDTACK), 32'd1);
        releaseBus();
        tick();
        chkIdle("abort idle");
        busCycle(22'h100000, 1'b1, 1'b0, 1'b1, 8'hFB, 4'b0111, 2, "rd r2 after abort");

        // Region 7: bus error when enabled, otherwise 3 wait states
`ifdef DECODE68K_BERR_EN
        bus.M68K_ADDR = 22'h380000;
        bus.M68K_RW   = 1'b1;
        bus.nUDS      = 1'b0;
        bus.nLDS      = 1'b0;
        bus.nAS       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("berr nberr", 32'(bus.nBERR), 32'd0);
            chk("berr dtack", 32'(bus.nDTACK), 32'd1);
            chk("berr strobes", 32'(strb()), 32'hF);
            chk("berr sel", 32'(bus.nREGION_SEL), 32'h7F);
        end
        releaseBus();
        tick();
        chkIdle("berr release");
`else
        busCycle(22'h380000, 1'b1, 1'b0, 1'b0, 8'h7F, 4'b0011, 4, "rd r7");
`endif

        // Reset mid-WAIT, then held nAS must not start a new cycle
        bus.M68K_ADDR = 22'h080000;
        bus.nUDS      = 1'b0;
        bus.nLDS      = 1'b0;
        bus.nAS       = 1'b0;
        tick();
        tick();
        chk("pre-reset sel", 32'(bus.nREGION_SEL), 32'hFD);
        nRESET = 1'b0;
        tick();
        chkIdle("mid-wait reset");
        nRESET = 1'b1;
        tick();
        chkIdle("no restart while nAS low");
        releaseBus();
        tick();

        // Reset while in ACK releases nDTACK at the reset edge
        bus.M68K_ADDR = 22'h000200;
        bus.nUDS      = 1'b0;
        bus.nAS       = 1'b0;
        tick();
        chk("ack before reset", 32'(bus.nDTACK), 32'd0);
        nRESET = 1'b0;
        tick();
        chkIdle("mid-ack reset");
        nRESET = 1'b1;
        releaseBus();

        // Free-running watchdog: pulse on clocks 101-104, restart, reset mid-pulse
        doReset();
        for (int k = 1; k <= 207; k++) begin
            tick();
            chk($sformatf("wd free k=%0d", k), 32'(bus.nWD_RESET),
                32'(((k >= 101 && k <= 104) || (k >= 206 && k <= 209)) ? 0 : 1));
        end
        nRESET = 1'b0;
        tick();
        chk("wd mid-pulse reset", 32'(bus.nWD_RESET), 32'd1);
        nRESET = 1'b1;

        // Kick landing on the limit clock suppresses the pulse and restarts the count
        doReset();
        for (int k = 1; k <= 100; k++) tick();
        chk("wd before kick", 32'(bus.nWD_RESET), 32'd1);
        bus.M68K_ADDR = 22'h028000;
        bus.M68K_RW   = 1'b1;
        bus.nUDS      = 1'b0;
        bus.nLDS      = 1'b0;
        bus.nAS       = 1'b0;
        for (int k = 101; k <= 210; k++) begin
            tick();
            if (k == 101) chk("kick dtack", 32'(bus.nDTACK), 32'd0);
            if (k == 102) releaseBus();
            chk($sformatf("wd kick k=%0d", k), 32'(bus.nWD_RESET),
                32'((k >= 202 && k <= 205) ? 0 : 1));
        end

        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
